snn_frame_sequencer: RTL and testbench
======================================

Name: snn_frame_sequencer

Overview:
- Upstream feeder and result collector for run_network.
- Accepts pixel data as a stream of WORD-bit words from the JTAG host side and assembles a HEIGHT-bit binary pixel frame.
- Holds the frame stable on run_network's pixels input, fires a one-cycle start, and times the fixed run length.
- Captures neuron_out/balance_out and returns them to the host through a valid/ready result port.

Parameters:
- WIDTH, 8, weight magnitude width of the attached network; used only to derive run length and balance width.
- HEIGHT, 784, number of pixels/synapses in the frame.
- WORD, 8, width of an input data word.
- SETTLE, 2, extra cycles waited after the network's iteration count expires, before sampling.
- Derived, not overridable: NWORDS = ceil(HEIGHT/WORD).
- Derived, not overridable: RUN_CYCLES = HEIGHT*(2**(WIDTH+1)+2).
- Derived, not overridable: BAL_W = $clog2(HEIGHT*(2**WIDTH-1)+1).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WORD  pixel word; bit WORD-1 is the earliest pixel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid&in_ready.
- pixels  out  HEIGHT  frame to run_network; pixels[HEIGHT-1] is the first pixel received.
- start  out  1  one-cycle start pulse to run_network.
- neuron_out  in  2  run_network class output.
- balance_out  in  BAL_W  run_network balance.
- res_class  out  2  captured class: 01 pos, 10 neg, 00 don't know, 11 error.
- res_balance  out  BAL_W  captured balance.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- busy  out  1  high in START/RUN/RESULT.

Behaviour:
- Reset (async): state=LOAD, word_cnt=0, run_cnt=0, pixels=0, start=0, res_class=0, res_balance=0, res_valid=0, busy=0. in_ready=1 the first cycle after reset release.
- FSM states: LOAD, START, RUN, RESULT.
- LOAD:
  - in_ready=1.
  - On handshake, word k (0-based) is written to pixels[HEIGHT-1-k*WORD -: WORD].
  - For the last word, bits beyond pixel HEIGHT-1 (the LSBs of in_data) are discarded.
  - word_cnt increments on each accepted word.
  - Accepting word NWORDS-1: word_cnt<=0, next state START.
- START:
  - start=1 for exactly this one cycle; in_ready=0.
  - run_cnt<=0; next state RUN.
- RUN:
  - start=0; run_cnt increments each cycle.
  - When run_cnt == RUN_CYCLES+SETTLE-1: capture neuron_out into res_class and balance_out into res_balance, set res_valid=1, next state RESULT.
  - Total cycles from the start cycle to the first res_valid: RUN_CYCLES+SETTLE+1.
- RESULT:
  - res_valid held high; res_class and res_balance are stable.
  - On res_valid&res_ready: res_valid<=0, next state LOAD.
  - pixels are held at all times outside LOAD word writes.
- in_valid during START/RUN/RESULT is ignored (in_ready=0) in the base build.
- rst mid-run: everything returns to reset values immediately; a partial frame is discarded; start drops asynchronously.
- Width: run_cnt is $clog2(RUN_CYCLES+SETTLE) bits and never wraps (compare-and-exit).
- res_class=11 is captured verbatim; the block takes no other action on it.

Optional Feature:
- Macro: SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN.
- When defined:
  - A second HEIGHT-bit shadow register and shadow word counter are added.
  - During START/RUN/RESULT, in_ready=1 until the shadow frame is complete, then 0.
  - On leaving RESULT with a complete shadow frame, the shadow is copied to pixels in the same cycle and the state goes directly to START (no LOAD visit).
  - An incomplete shadow continues loading in LOAD, writing into pixels at the shadow's word index.
  - Words accepted in LOAD and RUN share the same ordering rule.
- When undefined: behaviour exactly as above, with no shadow register.

Test Plan:
- HEIGHT=7,WIDTH=8,WORD=8, network stub holding neuron_out=01, balance_out=1234: send in_data=8'b1011001_1 -> pixels=7'b1011001; start high exactly 1 cycle; res_valid rises 3601 cycles after the start cycle; res_class=01, res_balance=1234.
- HEIGHT=784,WORD=8: send 98 words 0x00..0x61 -> pixels[783:776]=0x00 and pixels[7:0]=0x61; start asserted the cycle after the 98th handshake.
- Backpressure: hold res_ready=0 for 50 cycles -> res_valid and the result stay stable and in_ready=0 throughout; res_ready=1 -> res_valid falls next cycle and in_ready=1.
- Stub sets neuron_out=10 only at run_cnt=RUN_CYCLES -> captured res_class=10 (the settle window is honoured).
- Assert rst at run_cnt=1000 -> start=0, res_valid=0, busy=0, pixels=0; the next frame loads from word 0 correctly.
- With SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN: send frame B during the run of frame A -> after A's result handshake, pixels=B and start pulses the next cycle with no idle LOAD cycle.

Source files
------------

// File: rtl/snn_frame_sequencer.sv
// snn_frame_sequencer: assembles a HEIGHT-bit pixel frame from WORD-bit host
// words, launches run_network with a one-cycle start, times the fixed run
// and returns the captured class/balance through a valid/ready result port.
// Optional build macro: SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN adds a shadow
// frame that loads the next frame while the current one runs.
module snn_frame_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 784,
  parameter int unsigned WORD   = 8,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned BAL_W = $clog2(HEIGHT * (2**WIDTH - 1) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [HEIGHT-1:0] pixels,
  output logic              start,
  input  logic [1:0]        neuron_out,
  input  logic [BAL_W-1:0]  balance_out,
  output logic [1:0]        res_class,
  output logic [BAL_W-1:0]  res_balance,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  localparam int unsigned NWORDS     = (HEIGHT + WORD - 1) / WORD;
  localparam int unsigned RUN_CYCLES = HEIGHT * (2**(WIDTH + 1) + 2);
  localparam int unsigned LAST_RUN   = RUN_CYCLES + SETTLE - 1;
  localparam int unsigned CNT_W      = $clog2(RUN_CYCLES + SETTLE);
  localparam int unsigned WC_W       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PIX_IW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned BIT_IW     = (WORD > 1) ? $clog2(WORD) : 1;

  typedef enum logic [1:0] {LOAD, START, RUN, RESULT} state_t;

  state_t              state_q, state_n;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_n;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_n;
  logic [HEIGHT-1:0]   pixels_n;
  logic [1:0]          res_class_n;
  logic [BAL_W-1:0]    res_balance_n;
  logic                res_valid_n;
  logic                start_n;
  logic                busy_n;
  logic                in_ready_n;
  logic                accept;

`ifdef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
  logic [HEIGHT-1:0]   shadow_q, shadow_n;
  logic [WC_W-1:0]     scnt_q, scnt_n;
  logic                sfull_q, sfull_n;
`endif

  // Write word idx into a frame: pixel p (0 = first received) lives at
  // frame[HEIGHT-1-p]; within a word the MSB is the earliest pixel, and bits
  // that fall past the last pixel are dropped.
  function automatic logic [HEIGHT-1:0] put_word(input logic [HEIGHT-1:0] frame,
                                                 input logic [WC_W-1:0]   idx,
                                                 input logic [WORD-1:0]   data);
    logic [HEIGHT-1:0] f;
    f = frame;
    for (int p = 0; p < int'(HEIGHT); p++) begin
      if (idx == WC_W'(p / int'(WORD)))
        f[PIX_IW'(int'(HEIGHT) - 1 - p)] = data[BIT_IW'(int'(WORD) - 1 - (p % int'(WORD)))];
    end
    return f;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n       = state_q;
    word_cnt_n    = word_cnt_q;
    run_cnt_n     = run_cnt_q;
    pixels_n      = pixels;
    res_class_n   = res_class;
    res_balance_n = res_balance;
    res_valid_n   = res_valid;
    accept        = in_valid & in_ready;

`ifdef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
    shadow_n = shadow_q;
    scnt_n   = scnt_q;
    sfull_n  = sfull_q;
    if (accept && state_q != LOAD) begin
      shadow_n = put_word(shadow_q, scnt_q, in_data);
      if (scnt_q == WC_W'(NWORDS - 1)) begin
        scnt_n  = '0;
        sfull_n = 1'b1;
      end else begin
        scnt_n = scnt_q + WC_W'(1);
      end
    end
`endif

    case (state_q)
      LOAD: begin
        if (accept) begin
          pixels_n = put_word(pixels, word_cnt_q, in_data);
          if (word_cnt_q == WC_W'(NWORDS - 1)) begin
            word_cnt_n = '0;
            state_n    = START;
          end else begin
            word_cnt_n = word_cnt_q + WC_W'(1);
          end
        end
      end
      START: begin
        run_cnt_n = '0;
        state_n   = RUN;
      end
      RUN: begin
        if (run_cnt_q == CNT_W'(LAST_RUN)) begin
          res_class_n   = neuron_out;
          res_balance_n = balance_out;
          res_valid_n   = 1'b1;
          state_n       = RESULT;
        end else begin
          run_cnt_n = run_cnt_q + CNT_W'(1);
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          state_n     = LOAD;
`ifdef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
          if (sfull_n) begin
            pixels_n = shadow_n;
            sfull_n  = 1'b0;
            state_n  = START;
          end else if (scnt_n != '0) begin
            // Hand the partial frame over so LOAD resumes at the shadow index.
            pixels_n   = shadow_n;
            word_cnt_n = scnt_n;
            scnt_n     = '0;
          end
`endif
        end
      end
    endcase

    start_n = (state_n == START);
    busy_n  = (state_n != LOAD);
`ifdef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
    in_ready_n = (state_n == LOAD) || !sfull_n;
`else
    in_ready_n = (state_n == LOAD);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      word_cnt_q  <= '0;
      run_cnt_q   <= '0;
      pixels      <= '0;
      start       <= 1'b0;
      res_class   <= '0;
      res_balance <= '0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      state_q     <= state_n;
      word_cnt_q  <= word_cnt_n;
      run_cnt_q   <= run_cnt_n;
      pixels      <= pixels_n;
      start       <= start_n;
      res_class   <= res_class_n;
      res_balance <= res_balance_n;
      res_valid   <= res_valid_n;
      busy        <= busy_n;
      in_ready    <= in_ready_n;
    end
  end

`ifdef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
  // Shadow frame registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      scnt_q   <= '0;
      sfull_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_n;
      scnt_q   <= scnt_n;
      sfull_q  <= sfull_n;
    end
  end
`endif

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Bench for snn_frame_sequencer: a 7-pixel instance (a) and a 784-pixel
// instance (b), checked against a frame/latency model built from words.
module tb_snn_frame_sequencer;

  localparam int unsigned HA = 7;
  localparam int unsigned WA = 8;
  localparam int unsigned HB = 784;
  localparam int unsigned WB = 1;
  localparam int unsigned SET = 2;
  localparam int unsigned RCA = HA * (2**(WA + 1) + 2);
  localparam int unsigned RCB = HB * (2**(WB + 1) + 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]    in_data_a, in_data_b;
  logic          in_valid_a, in_valid_b, in_ready_a, in_ready_b;
  logic [HA-1:0] pixels_a;
  logic [HB-1:0] pixels_b;
  logic          start_a, start_b;
  logic [1:0]    neuron_a, neuron_b, res_class_a, res_class_b;
  logic [10:0]   bal_a, res_bal_a;
  logic [9:0]    bal_b, res_bal_b;
  logic          res_valid_a, res_valid_b, res_ready_a, res_ready_b;
  logic          busy_a, busy_b;

  snn_frame_sequencer #(.WIDTH(WA), .HEIGHT(HA), .WORD(8), .SETTLE(SET)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .pixels(pixels_a), .start(start_a),
    .neuron_out(neuron_a), .balance_out(bal_a), .res_class(res_class_a),
    .res_balance(res_bal_a), .res_valid(res_valid_a), .res_ready(res_ready_a),
    .busy(busy_a));

  snn_frame_sequencer #(.WIDTH(WB), .HEIGHT(HB), .WORD(8), .SETTLE(SET)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .pixels(pixels_b), .start(start_b),
    .neuron_out(neuron_b), .balance_out(bal_b), .res_class(res_class_b),
    .res_balance(res_bal_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .busy(busy_b));

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame as the host sees it: words concatenated MSB-first, first HEIGHT bits kept.
  function automatic logic [1023:0] model_frame(input logic [7:0] words[$], input int h);
    logic [1023:0] acc;
    acc = '0;
    foreach (words[i]) acc = (acc << 8) | 1024'(words[i]);
    return acc >> (words.size() * 8 - h);
  endfunction

  task automatic send_a(input logic [7:0] w, input string tag);
    int t;
    t = 0;
    in_data_a  = w;
    in_valid_a = 1'b1;
    while (!in_ready_a && t < 100) begin step(); t++; end
    check({tag, "_ready"}, in_ready_a, 1'b1);
    step();
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w, input string tag);
    int t;
    t = 0;
    in_data_b  = w;
    in_valid_b = 1'b1;
    while (!in_ready_b && t < 100) begin step(); t++; end
    check({tag, "_ready"}, in_ready_b, 1'b1);
    step();
    in_valid_b = 1'b0;
  endtask

  // Called on the start cycle; counts cycles until res_valid.
  task automatic wait_res_a(input bit settle_flip, output int lat);
    lat = 0;
    while (!res_valid_a && lat < 20000) begin
      step();
      lat++;
      if (lat == 1) check("a_start_one_cycle", start_a, 1'b0);
      if (settle_flip && lat == int'(RCA) + 1) begin
        neuron_a = 2'b10;
        bal_a    = 11'd999;
      end
    end
  endtask

  task automatic wait_res_b(output int lat);
    lat = 0;
    while (!res_valid_b && lat < 20000) begin
      step();
      lat++;
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] w;
    logic [1:0] cls;
    logic [10:0] bal;
    int lat;

    rst = 1'b1;
    in_valid_a = 0; in_data_a = 0; neuron_a = 0; bal_a = 0; res_ready_a = 0;
    in_valid_b = 0; in_data_b = 0; neuron_b = 0; bal_b = 0; res_ready_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", start_a, 1'b0);
    check("rst_res_valid", res_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_pixels", pixels_a, 7'd0);
    check("rst_res_class", res_class_a, 2'd0);
    check("rst_res_balance", res_bal_a, 11'd0);
    check("rst_b_pixels", pixels_b, '0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready_a", in_ready_a, 1'b1);
    check("post_rst_in_ready_b", in_ready_b, 1'b1);

    // Directed frame with known stub values
    neuron_a = 2'b01;
    bal_a    = 11'd1234;
    send_a(8'b1011001_1, "a0");
    check("a0_start", start_a, 1'b1);
    check("a0_busy", busy_a, 1'b1);
    check("a0_in_ready_low", in_ready_a, 1'b0);
    check("a0_pixels", pixels_a, 7'b1011001);
`ifndef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
    in_valid_a = 1'b1;
    in_data_a  = 8'h55;
`endif
    wait_res_a(1'b0, lat);
    in_valid_a = 1'b0;
    check("a0_latency", lat, RCA + SET + 1);
    check("a0_class", res_class_a, 2'b01);
    check("a0_balance", res_bal_a, 11'd1234);
    check("a0_pixels_held", pixels_a, 7'b1011001);

    // Backpressure: result must stay put while the stub moves
    neuron_a = 2'b10;
    bal_a    = 11'd77;
    for (int i = 0; i < 50; i++) begin
      step();
      check("bp_valid", res_valid_a, 1'b1);
      check("bp_class", res_class_a, 2'b01);
      check("bp_balance", res_bal_a, 11'd1234);
`ifndef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
      check("bp_in_ready", in_ready_a, 1'b0);
`endif
    end
    res_ready_a = 1'b1;
    step();
    res_ready_a = 1'b0;
    check("bp_valid_fall", res_valid_a, 1'b0);
    check("bp_in_ready_back", in_ready_a, 1'b1);
    check("bp_busy_fall", busy_a, 1'b0);

    // Settle window: class changes only once run_cnt reaches RUN_CYCLES
    neuron_a = 2'b01;
    bal_a    = 11'd5;
    w = 8'($urandom);
    send_a(w, "settle");
    wait_res_a(1'b1, lat);
    check("settle_latency", lat, RCA + SET + 1);
    check("settle_class", res_class_a, 2'b10);
    check("settle_balance", res_bal_a, 11'd999);
    res_ready_a = 1'b1;
    step();
    res_ready_a = 1'b0;

    // Reset in the middle of a run
    w = 8'($urandom);
    send_a(w, "midrst");
    repeat (1001) step();
    check("midrst_running", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_start", start_a, 1'b0);
    check("midrst_valid", res_valid_a, 1'b0);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_pixels", pixels_a, 7'd0);
    step();
    rst = 1'b0;
    step();
    check("midrst_in_ready", in_ready_a, 1'b1);

    // Reset on the start cycle drops start without waiting for a clock
    send_a(8'hF0, "startrst");
    check("startrst_start_hi", start_a, 1'b1);
    rst = 1'b1;
    #1;
    check("startrst_start_async", start_a, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Random frames against the model
    for (int f = 0; f < 3; f++) begin
      w   = 8'($urandom);
      cls = 2'($urandom);
      bal = 11'($urandom);
      neuron_a = cls;
      bal_a    = bal;
      send_a(w, "rnd");
      q.delete();
      q.push_back(w);
      check("rnd_start", start_a, 1'b1);
      check("rnd_pixels", pixels_a, model_frame(q, HA));
      wait_res_a(1'b0, lat);
      check("rnd_latency", lat, RCA + SET + 1);
      check("rnd_class", res_class_a, cls);
      check("rnd_balance", res_bal_a, bal);
      repeat ($urandom_range(0, 4)) begin
        step();
        check("rnd_valid_hold", res_valid_a, 1'b1);
      end
      res_ready_a = 1'b1;
      step();
      res_ready_a = 1'b0;
      check("rnd_valid_fall", res_valid_a, 1'b0);
    end

`ifdef SNN_FRAME_SEQUENCER_DOUBLE_BUFFER_EN
    // Frame B loads into the shadow while frame A runs
    neuron_a = 2'b01;
    bal_a    = 11'd3;
    send_a(8'hA5, "db_a");
    repeat (3) step();
    send_a(8'h3C, "db_b");
    step();
    check("db_shadow_full_ready", in_ready_a, 1'b0);
    check("db_a_pixels_held", pixels_a, 7'(8'hA5 >> 1));
    wait_res_a(1'b0, lat);
    res_ready_a = 1'b1;
    step();
    res_ready_a = 1'b0;
    check("db_pixels_b", pixels_a, 7'(8'h3C >> 1));
    check("db_start", start_a, 1'b1);
    check("db_busy", busy_a, 1'b1);
    wait_res_a(1'b0, lat);
    check("db_b_latency", lat, RCA + SET + 1);
    res_ready_a = 1'b1;
    step();
    res_ready_a = 1'b0;
`endif

    // 784-pixel frame of words 0x00..0x61 with idle gaps
    neuron_b = 2'b11;
    bal_b    = 10'($urandom);
    q.delete();
    for (int i = 0; i < 98; i++) begin
      q.push_back(8'(i));
      if ($urandom_range(0, 3) == 0) step();
      send_b(8'(i), "b_word");
      if (i == 96) check("b_no_early_start", start_b, 1'b0);
    end
    check("b_start", start_b, 1'b1);
    check("b_pixels", pixels_b, model_frame(q, HB));
    check("b_px_hi", pixels_b[783:776], 8'h00);
    check("b_px_lo", pixels_b[7:0], 8'h61);
    wait_res_b(lat);
    check("b_latency", lat, RCB + SET + 1);
    check("b_class_err", res_class_b, 2'b11);
    check("b_balance", res_bal_b, bal_b);
    res_ready_b = 1'b1;
    step();
    res_ready_b = 1'b0;
    check("b_valid_fall", res_valid_b, 1'b0);

    // Second random 784-pixel frame restarts at word 0
    q.delete();
    neuron_b = 2'b10;
    for (int i = 0; i < 98; i++) begin
      w = 8'($urandom);
      q.push_back(w);
      send_b(w, "b2_word");
    end
    check("b2_start", start_b, 1'b1);
    check("b2_pixels", pixels_b, model_frame(q, HB));
    wait_res_b(lat);
    check("b2_latency", lat, RCB + SET + 1);
    check("b2_class", res_class_b, 2'b10);
    res_ready_b = 1'b1;
    step();
    res_ready_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
